// File: rtl/incr_pkg.sv
// Shared helpers for the pipelined incrementor.
package incr_pkg;

  // Number of pipeline stages needed to cover width bits in chunk-bit segments.
  function automatic int stages(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/incr_chunk.sv
// Combinational increment of one segment with carry-in and carry-out.
module incr_chunk #(
  parameter int N = 8
) (
  input  logic [N-1:0] operand,
  input  logic         cin,
  output logic [N-1:0] result,
  output logic         co
);

  assign result = operand + N'(cin);
  // Carry ripples out only when the whole segment is all-ones.
  assign co     = cin & (&operand);

endmodule

// File: rtl/incr_pipe.sv
// Pipelined incrementor: one chunk of the operand is resolved per stage,
// with valid/ready flow control, optional saturation and overflow flag.
module incr_pipe
  import incr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_en,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cy
);

  localparam int STAGES = stages(WIDTH, CHUNK);

  // cin is the carry into the next chunk still to be processed.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             en;
    logic             sat;
    logic             cin;
  } stage_t;

  stage_t            stage_q [STAGES];
  logic [STAGES-1:0] vld;
  logic [STAGES:0]   rdy;

  // Backward ready chain: a stage can load when it is empty or its successor moves.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy[i] = !vld[i] || rdy[i+1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * CHUNK;
    // The final stage takes whatever bits remain, which may be fewer than CHUNK.
    localparam int N  = (gi == STAGES - 1) ? (WIDTH - LO) : CHUNK;

    stage_t         stage_src;
    stage_t         stage_next;
    stage_t         stage_reg;
    logic           vld_src;
    logic           vld_reg;
    logic [N-1:0]   chunk_sum;
    logic           chunk_co;

    if (gi == 0) begin : g_head
      // The first carry-in is the per-transaction enable.
      assign stage_src = '{data: in_data, en: in_en, sat: in_sat, cin: in_en};
      assign vld_src   = in_valid;
    end else begin : g_body
      assign stage_src = stage_q[gi-1];
      assign vld_src   = vld[gi-1];
    end

    incr_chunk #(.N(N)) u_chunk (
      .operand (stage_src.data[LO +: N]),
      .cin     (stage_src.cin),
      .result  (chunk_sum),
      .co      (chunk_co)
    );

    // Replace this stage's chunk with its incremented value and pass the carry on.
    always_comb begin
      stage_next                = stage_src;
      stage_next.data[LO +: N]  = chunk_sum;
      stage_next.cin            = chunk_co;
    end

    // Stage register: loads whenever ready, otherwise holds its contents.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_reg   <= 1'b0;
        stage_reg <= '0;
      end else if (rdy[gi]) begin
        vld_reg   <= vld_src;
        stage_reg <= stage_next;
      end
    end

    assign vld[gi]     = vld_reg;
    assign stage_q[gi] = stage_reg;
  end

  stage_t last_stage;
  assign last_stage = stage_q[STAGES-1];

  // Outputs come straight from the last stage register; in saturate mode an
  // overflow (wrapped to zero) is forced back to all-ones.
  assign out_valid = vld[STAGES-1];
  assign out_data  = last_stage.data | {WIDTH{last_stage.cin & last_stage.sat}};
  assign out_cy    = last_stage.cin & last_stage.en;

endmodule
